// File: rtl/rv_sched_pkg.sv
// Shared types and header helpers for the ready-valid channel scheduler.
// Header byte: bit 7 = direction (1 = host->device), bits 6:4 = 0, bits 3:0 = channel id.
package rv_sched_pkg;

  typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA} read_state_e;
  typedef enum logic       {W_HDR, W_DATA}         write_state_e;

  localparam int HDR_DIR_BIT = 7;
  localparam int CH_ID_WIDTH = 4;

  function automatic logic [7:0] make_header(input logic dir,
                                             input logic [CH_ID_WIDTH-1:0] id);
    logic [7:0] hdr;
    hdr              = {4'b0000, id};
    hdr[HDR_DIR_BIT] = dir;
    return hdr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// strictly above last_grant, wrapping to the lowest requester otherwise.
module rr_arbiter
  import rv_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]      req,
  input  logic [CH_ID_WIDTH-1:0] last_grant,
  output logic [NUM_CH-1:0]      grant
);

  logic [NUM_CH-1:0] above_mask;
  logic [NUM_CH-1:0] req_hi;

  always_comb begin
    above_mask = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      above_mask[j] = (CH_ID_WIDTH'(j) > last_grant);
    end
  end

  assign req_hi = req & above_mask;

  // Isolate the lowest set bit; fall back to the unmasked vector on wrap.
  always_comb begin
    if (|req_hi) begin
      grant = req_hi & (~req_hi + NUM_CH'(1));
    end else begin
      grant = req & (~req + NUM_CH'(1));
    end
  end

endmodule

// File: rtl/rv_channel_scheduler.sv
// Shares one byte-wide ready-valid register interface between NUM_CH channels:
// a round-robin read serialiser and an independent host-write frame parser.
module rv_channel_scheduler
  import rv_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int BYTES  = 4
) (
  input  logic                      CLK_I,
  input  logic                      RST_NI,
  input  logic [NUM_CH-1:0]         CH_REQ_I,
  input  logic [NUM_CH*8*BYTES-1:0] CH_DATA_I,
  output logic [NUM_CH-1:0]         CH_ACK_O,
  output logic [8*BYTES-1:0]        CH_WDATA_O,
  output logic [NUM_CH-1:0]         CH_WVALID_O,
  output logic                      ERR_O,
  output logic                      RV_READ_ENABLE_O,
  output logic                      RV_CHANGE_O,
  output logic [7:0]                RV_DATA_O,
  input  logic                      RV_READ_I,
  output logic                      RV_WRITE_ENABLE_O,
  input  logic                      RV_UPDATE_I,
  input  logic [7:0]                RV_DATA_I
);

  localparam int                WORD_W   = 8 * BYTES;
  localparam int                IDX_W    = $clog2(BYTES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);

  read_state_e             rd_state_q, rd_state_d;
  logic [NUM_CH-1:0]       grant_oh_q, grant_oh_d;
  logic [CH_ID_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic [CH_ID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d, rd_idx_inc;
  logic [7:0]              rv_data_d, rd_next_byte;
  logic                    rv_change_d;
  logic [NUM_CH-1:0]       ack_d;
  logic [NUM_CH-1:0]       arb_grant;
  logic [CH_ID_WIDTH-1:0]  arb_id;
  logic [WORD_W-1:0]       snap_sel, snap_q;
  logic                    snap_load;

  write_state_e            wr_state_q, wr_state_d;
  logic [CH_ID_WIDTH-1:0]  wr_id_q, wr_id_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [WORD_W-1:0]       wbuf_q, wbuf_merged, wdata_d;
  logic                    wbuf_we;
  logic [NUM_CH-1:0]       wvalid_d, wr_id_oh;
  logic                    err_d;
  logic                    hdr_id_ok;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (CH_REQ_I),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  always_comb begin
    arb_id   = '0;
    snap_sel = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (arb_grant[j]) begin
        arb_id   = CH_ID_WIDTH'(j);
        snap_sel = CH_DATA_I[j*WORD_W +: WORD_W];
      end
    end
  end

  assign rd_idx_inc = rd_idx_q + IDX_W'(1);

  always_comb begin
    rd_next_byte = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (rd_idx_inc == IDX_W'(b)) rd_next_byte = snap_q[b*8 +: 8];
    end
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    grant_oh_d   = grant_oh_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    rd_idx_d     = rd_idx_q;
    rv_data_d    = RV_DATA_O;
    rv_change_d  = 1'b0;
    ack_d        = '0;
    snap_load    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (|CH_REQ_I) begin
          rd_state_d  = R_HDR;
          grant_oh_d  = arb_grant;
          grant_id_d  = arb_id;
          snap_load   = 1'b1;
          rv_data_d   = make_header(1'b0, arb_id);
          rv_change_d = 1'b1;
        end
      end
      R_HDR: begin
        if (RV_READ_I) begin
          rd_state_d  = R_DATA;
          rd_idx_d    = '0;
          rv_data_d   = snap_q[7:0];
          rv_change_d = 1'b1;
        end
      end
      R_DATA: begin
        if (RV_READ_I) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_state_d   = R_IDLE;
            ack_d        = grant_oh_q;
            last_grant_d = grant_id_q;
          end else begin
            rd_idx_d    = rd_idx_inc;
            rv_data_d   = rd_next_byte;
            rv_change_d = 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rd_state_q   <= R_IDLE;
      grant_oh_q   <= '0;
      grant_id_q   <= '0;
      last_grant_q <= CH_ID_WIDTH'(NUM_CH - 1);
      rd_idx_q     <= '0;
      RV_DATA_O    <= '0;
      RV_CHANGE_O  <= 1'b0;
      CH_ACK_O     <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      grant_oh_q   <= grant_oh_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      rd_idx_q     <= rd_idx_d;
      RV_DATA_O    <= rv_data_d;
      RV_CHANGE_O  <= rv_change_d;
      CH_ACK_O     <= ack_d;
    end
  end

  // The snapshot decouples the frame from later changes on CH_DATA_I.
  always_ff @(posedge CLK_I) begin
    if (snap_load) snap_q <= snap_sel;
  end

  assign RV_READ_ENABLE_O = (rd_state_q != R_IDLE);

  assign hdr_id_ok = ({1'b0, RV_DATA_I[CH_ID_WIDTH-1:0]} < (CH_ID_WIDTH + 1)'(NUM_CH));

  always_comb begin
    wbuf_merged = wbuf_q;
    for (int b = 0; b < BYTES; b++) begin
      if (wr_idx_q == IDX_W'(b)) wbuf_merged[b*8 +: 8] = RV_DATA_I;
    end
  end

  always_comb begin
    wr_id_oh = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      wr_id_oh[j] = (wr_id_q == CH_ID_WIDTH'(j));
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_idx_d   = wr_idx_q;
    wdata_d    = CH_WDATA_O;
    wvalid_d   = '0;
    err_d      = 1'b0;
    wbuf_we    = 1'b0;
    case (wr_state_q)
      W_HDR: begin
        if (RV_UPDATE_I) begin
          if (RV_DATA_I[HDR_DIR_BIT] && hdr_id_ok) begin
            wr_state_d = W_DATA;
            wr_id_d    = RV_DATA_I[CH_ID_WIDTH-1:0];
            wr_idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      W_DATA: begin
        if (RV_UPDATE_I) begin
          wbuf_we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_state_d = W_HDR;
            wdata_d    = wbuf_merged;
            wvalid_d   = wr_id_oh;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      default: wr_state_d = W_HDR;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      wr_state_q        <= W_HDR;
      wr_id_q           <= '0;
      wr_idx_q          <= '0;
      CH_WDATA_O        <= '0;
      CH_WVALID_O       <= '0;
      ERR_O             <= 1'b0;
      RV_WRITE_ENABLE_O <= 1'b0;
    end else begin
      wr_state_q        <= wr_state_d;
      wr_id_q           <= wr_id_d;
      wr_idx_q          <= wr_idx_d;
      CH_WDATA_O        <= wdata_d;
      CH_WVALID_O       <= wvalid_d;
      ERR_O             <= err_d;
      RV_WRITE_ENABLE_O <= 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (wbuf_we) wbuf_q <= wbuf_merged;
  end

endmodule

// File: tb/tb_rv_channel_scheduler.sv
// Directed bench for rv_channel_scheduler (NUM_CH=4, BYTES=2): arbitration,
// byte order, host writes, header errors, concurrency and mid-frame reset.
module tb_rv_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int BYTES  = 2;
  localparam int W      = 8 * BYTES;

  logic                  CLK_I = 1'b0;
  logic                  RST_NI = 1'b0;
  logic [NUM_CH-1:0]     CH_REQ_I = '0;
  logic [NUM_CH*W-1:0]   CH_DATA_I = '0;
  logic [NUM_CH-1:0]     CH_ACK_O;
  logic [W-1:0]          CH_WDATA_O;
  logic [NUM_CH-1:0]     CH_WVALID_O;
  logic                  ERR_O;
  logic                  RV_READ_ENABLE_O;
  logic                  RV_CHANGE_O;
  logic [7:0]            RV_DATA_O;
  logic                  RV_READ_I = 1'b0;
  logic                  RV_WRITE_ENABLE_O;
  logic                  RV_UPDATE_I = 1'b0;
  logic [7:0]            RV_DATA_I = '0;

  int errors = 0;
  int checks = 0;

  rv_channel_scheduler #(.NUM_CH(NUM_CH), .BYTES(BYTES)) dut (
    .CLK_I             (CLK_I),
    .RST_NI            (RST_NI),
    .CH_REQ_I          (CH_REQ_I),
    .CH_DATA_I         (CH_DATA_I),
    .CH_ACK_O          (CH_ACK_O),
    .CH_WDATA_O        (CH_WDATA_O),
    .CH_WVALID_O       (CH_WVALID_O),
    .ERR_O             (ERR_O),
    .RV_READ_ENABLE_O  (RV_READ_ENABLE_O),
    .RV_CHANGE_O       (RV_CHANGE_O),
    .RV_DATA_O         (RV_DATA_O),
    .RV_READ_I         (RV_READ_I),
    .RV_WRITE_ENABLE_O (RV_WRITE_ENABLE_O),
    .RV_UPDATE_I       (RV_UPDATE_I),
    .RV_DATA_I         (RV_DATA_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_change(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (RV_CHANGE_O === 1'b1) break;
      @(negedge CLK_I);
    end
    check({tag, "_change"}, 32'(RV_CHANGE_O), 32'h1);
  endtask

  task automatic pulse_read();
    @(negedge CLK_I);
    RV_READ_I = 1'b1;
    @(negedge CLK_I);
    RV_READ_I = 1'b0;
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp);
    wait_change(tag);
    check(tag, 32'(RV_DATA_O), 32'(exp));
    pulse_read();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RV_DATA_I   = b;
    RV_UPDATE_I = 1'b1;
    @(negedge CLK_I);
    RV_UPDATE_I = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"},  32'(RV_DATA_O),         32'h0);
    check({tag, "_change"}, 32'(RV_CHANGE_O),       32'h0);
    check({tag, "_ack"},    32'(CH_ACK_O),          32'h0);
    check({tag, "_wvalid"}, 32'(CH_WVALID_O),       32'h0);
    check({tag, "_wdata"},  32'(CH_WDATA_O),        32'h0);
    check({tag, "_err"},    32'(ERR_O),             32'h0);
    check({tag, "_ren"},    32'(RV_READ_ENABLE_O),  32'h0);
    check({tag, "_wen"},    32'(RV_WRITE_ENABLE_O), 32'h0);
  endtask

  initial begin
    CH_DATA_I[0*W +: W] = 16'h5566;
    CH_DATA_I[1*W +: W] = 16'hC1D1;
    CH_DATA_I[2*W +: W] = 16'h2222;
    CH_DATA_I[3*W +: W] = 16'hE3F3;

    // Power-on reset
    @(negedge CLK_I);
    @(negedge CLK_I);
    check_all_zero("por");
    RST_NI = 1'b1;
    @(negedge CLK_I);
    check("por_wen_up", 32'(RV_WRITE_ENABLE_O), 32'h1);
    check("por_ren_idle", 32'(RV_READ_ENABLE_O), 32'h0);

    // Round-robin between channels 1 and 3
    CH_REQ_I = 4'b1010;
    wait_change("rr_h1");
    check("rr_ren", 32'(RV_READ_ENABLE_O), 32'h1);
    read_byte("rr_h1", 8'h01);
    read_byte("rr_b1lo", 8'hD1);
    read_byte("rr_b1hi", 8'hC1);
    check("rr_ack1", 32'(CH_ACK_O), 32'h2);
    check("rr_ren_idle", 32'(RV_READ_ENABLE_O), 32'h0);
    @(negedge CLK_I);
    check("rr_ack1_single", 32'(CH_ACK_O), 32'h0);
    read_byte("rr_h3", 8'h03);
    read_byte("rr_b3lo", 8'hF3);
    read_byte("rr_b3hi", 8'hE3);
    check("rr_ack3", 32'(CH_ACK_O), 32'h8);
    @(negedge CLK_I);
    check("rr_ack3_single", 32'(CH_ACK_O), 32'h0);
    // Channel 1 is granted again here; withdrawing the request must not abort it.
    CH_REQ_I = 4'b0000;
    read_byte("rr_h1b", 8'h01);
    read_byte("rr_b1blo", 8'hD1);
    read_byte("rr_b1bhi", 8'hC1);
    check("rr_ack1b", 32'(CH_ACK_O), 32'h2);

    // Byte order and snapshot isolation
    CH_DATA_I[2*W +: W] = 16'hA1B2;
    CH_REQ_I = 4'b0100;
    read_byte("bo_hdr", 8'h02);
    CH_DATA_I[2*W +: W] = 16'hFFFF;
    read_byte("bo_b0", 8'hB2);
    read_byte("bo_b1", 8'hA1);
    check("bo_ack", 32'(CH_ACK_O), 32'h4);
    CH_REQ_I = 4'b0000;
    @(negedge CLK_I);

    // Host write to channel 2
    send_byte(8'h82);
    send_byte(8'h34);
    send_byte(8'h12);
    check("hw_wvalid", 32'(CH_WVALID_O), 32'h4);
    check("hw_wdata", 32'(CH_WDATA_O), 32'h1234);
    @(negedge CLK_I);
    check("hw_wvalid_single", 32'(CH_WVALID_O), 32'h0);
    check("hw_wdata_hold", 32'(CH_WDATA_O), 32'h1234);

    // Invalid header followed by a good frame
    send_byte(8'h05);
    check("inv_err", 32'(ERR_O), 32'h1);
    send_byte(8'h81);
    check("inv_err_once", 32'(ERR_O), 32'h0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    check("inv_wvalid", 32'(CH_WVALID_O), 32'h2);
    check("inv_wdata", 32'(CH_WDATA_O), 32'hBEEF);
    check("inv_no_err", 32'(ERR_O), 32'h0);
    @(negedge CLK_I);

    // Coinciding RV_READ_I and RV_UPDATE_I
    CH_REQ_I = 4'b0001;
    send_byte(8'h83);
    wait_change("cc_hdr");
    check("cc_hdr", 32'(RV_DATA_O), 32'h00);
    @(negedge CLK_I);
    RV_READ_I = 1'b1; RV_UPDATE_I = 1'b1; RV_DATA_I = 8'h77;
    @(negedge CLK_I);
    RV_READ_I = 1'b0; RV_UPDATE_I = 1'b0;
    check("cc_b0_change", 32'(RV_CHANGE_O), 32'h1);
    check("cc_b0", 32'(RV_DATA_O), 32'h66);
    @(negedge CLK_I);
    RV_READ_I = 1'b1; RV_UPDATE_I = 1'b1; RV_DATA_I = 8'h88;
    @(negedge CLK_I);
    RV_READ_I = 1'b0; RV_UPDATE_I = 1'b0;
    check("cc_b1", 32'(RV_DATA_O), 32'h55);
    check("cc_wvalid", 32'(CH_WVALID_O), 32'h8);
    check("cc_wdata", 32'(CH_WDATA_O), 32'h8877);
    CH_REQ_I = 4'b0000;
    pulse_read();
    check("cc_ack", 32'(CH_ACK_O), 32'h1);
    @(negedge CLK_I);

    // Reset mid-read and mid-write
    CH_REQ_I = 4'b0010;
    read_byte("rst_hdr", 8'h01);
    send_byte(8'h82);
    send_byte(8'h11);
    check("rst_pre_rdata", 32'(RV_DATA_O), 32'hD1);
    #2;
    RST_NI = 1'b0;
    #1;
    check_all_zero("rst");
    CH_REQ_I = 4'b0011;
    @(negedge CLK_I);
    RST_NI = 1'b1;
    @(negedge CLK_I);
    check("rst_wen_up", 32'(RV_WRITE_ENABLE_O), 32'h1);
    check("rst_no_ack", 32'(CH_ACK_O), 32'h0);
    check("rst_no_wvalid", 32'(CH_WVALID_O), 32'h0);
    check("rst_first_change", 32'(RV_CHANGE_O), 32'h1);
    check("rst_first_grant", 32'(RV_DATA_O), 32'h00);
    CH_REQ_I = 4'b0000;
    pulse_read();
    read_byte("rst_b0", 8'h66);
    read_byte("rst_b1", 8'h55);
    check("rst_ack0", 32'(CH_ACK_O), 32'h1);
    send_byte(8'h83);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("rst_wvalid", 32'(CH_WVALID_O), 32'h8);
    check("rst_wdata", 32'(CH_WDATA_O), 32'hBBAA);
    @(negedge CLK_I);
    check("rst_wvalid_single", 32'(CH_WVALID_O), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
